// File: rtl/reg_writeback_arbiter.sv
// Write-port owner for the OTTER 32x32 register file: merges the never-stalled
// pipeline writeback with a FIFO-buffered long-latency source and tracks pending registers.
module reg_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            A_VALID,
    input  logic [4:0]      A_ADDR,
    input  logic [XLEN-1:0] A_DATA,
    input  logic            L_VALID,
    output logic            L_READY,
    input  logic [4:0]      L_ADDR,
    input  logic [XLEN-1:0] L_DATA,
    input  logic            ISSUE_EN,
    input  logic [4:0]      ISSUE_ADDR,
    input  logic [4:0]      CHK_ADDR1,
    input  logic [4:0]      CHK_ADDR2,
    output logic            BUSY1,
    output logic            BUSY2,
    output logic            WR_EN,
    output logic [4:0]      WR_ADDR,
    output logic [XLEN-1:0] WR_DATA,
    output logic [2:0]      COUNT
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]       fifo_addr [DEPTH];
    logic [XLEN-1:0]  fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       count;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;

    logic             a_eff;
    logic             push;
    logic             pop;
    logic             pop_write;
    logic [4:0]       head_addr;
    logic [XLEN-1:0]  head_data;

    // Ready looks only at registered occupancy, so a full FIFO never passes through on a pop.
    assign L_READY   = (count != 3'(DEPTH));
    assign COUNT     = count;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign BUSY1     = pending[CHK_ADDR1];
    assign BUSY2     = pending[CHK_ADDR2];

    always_comb begin
        a_eff     = A_VALID && (A_ADDR != 5'd0);
        push      = L_VALID && L_READY;
        pop       = !a_eff && (count != 3'd0);
        pop_write = pop && (head_addr != 5'd0);
    end

    // Issue set is applied after the pop clear so a same-cycle collision leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (pop_write) begin
            pending_nxt[head_addr] = 1'b0;
        end
        if (ISSUE_EN && (ISSUE_ADDR != 5'd0)) begin
            pending_nxt[ISSUE_ADDR] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= L_ADDR;
            fifo_data[wr_ptr] <= L_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Address/data hold their last value on idle cycles and on discarded x0 pops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WR_EN   <= 1'b0;
            WR_ADDR <= 5'd0;
            WR_DATA <= '0;
        end else begin
            WR_EN <= a_eff || pop_write;
            if (a_eff) begin
                WR_ADDR <= A_ADDR;
                WR_DATA <= A_DATA;
            end else if (pop_write) begin
                WR_ADDR <= head_addr;
                WR_DATA <= head_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Randomized and directed bench for reg_writeback_arbiter against a queue-based reference model.
module tb_reg_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            A_VALID;
    logic [4:0]      A_ADDR;
    logic [XLEN-1:0] A_DATA;
    logic            L_VALID;
    logic            L_READY;
    logic [4:0]      L_ADDR;
    logic [XLEN-1:0] L_DATA;
    logic            ISSUE_EN;
    logic [4:0]      ISSUE_ADDR;
    logic [4:0]      CHK_ADDR1;
    logic [4:0]      CHK_ADDR2;
    logic            BUSY1;
    logic            BUSY2;
    logic            WR_EN;
    logic [4:0]      WR_ADDR;
    logic [XLEN-1:0] WR_DATA;
    logic [2:0]      COUNT;

    reg_writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .L_VALID(L_VALID), .L_READY(L_READY), .L_ADDR(L_ADDR), .L_DATA(L_DATA),
        .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR),
        .CHK_ADDR1(CHK_ADDR1), .CHK_ADDR2(CHK_ADDR2),
        .BUSY1(BUSY1), .BUSY2(BUSY2),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          model_q[$];
    bit   [31:0]     model_pend;
    logic            exp_en;
    logic [4:0]      exp_addr;
    logic [XLEN-1:0] exp_data;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic ie, input logic [4:0] ia,
                                 input logic [4:0] c1, input logic [4:0] c2);
        A_VALID = av;  A_ADDR = aa;  A_DATA = ad;
        L_VALID = lv;  L_ADDR = la;  L_DATA = ld;
        ISSUE_EN = ie; ISSUE_ADDR = ia;
        CHK_ADDR1 = c1; CHK_ADDR2 = c2;
    endtask

    task automatic modelReset();
        model_q.delete();
        model_pend = 32'd0;
        exp_en     = 1'b0;
        exp_addr   = 5'd0;
        exp_data   = '0;
    endtask

    // Called with inputs already driven in the low phase; ends at the next falling edge.
    task automatic stepCycle();
        entry_t e;
        bit a_eff;
        bit ready;
        #1;
        ready = (model_q.size() != DEPTH);
        checkOutput("l_ready", L_READY, ready);
        checkOutput("count", COUNT, model_q.size());
        checkOutput("busy1", BUSY1, model_pend[CHK_ADDR1]);
        checkOutput("busy2", BUSY2, model_pend[CHK_ADDR2]);
        a_eff  = A_VALID && (A_ADDR != 5'd0);
        exp_en = 1'b0;
        if (a_eff) begin
            exp_en   = 1'b1;
            exp_addr = A_ADDR;
            exp_data = A_DATA;
        end else if (model_q.size() > 0) begin
            e = model_q.pop_front();
            if (e.addr != 5'd0) begin
                exp_en   = 1'b1;
                exp_addr = e.addr;
                exp_data = e.data;
                model_pend[e.addr] = 1'b0;
            end
        end
        if (L_VALID && ready) begin
            e.addr = L_ADDR;
            e.data = L_DATA;
            model_q.push_back(e);
        end
        if (ISSUE_EN && (ISSUE_ADDR != 5'd0)) begin
            model_pend[ISSUE_ADDR] = 1'b1;
        end
        @(posedge CLK);
        #1;
        checkOutput("wr_en", WR_EN, exp_en);
        checkOutput("wr_addr", WR_ADDR, exp_addr);
        checkOutput("wr_data", WR_DATA, exp_data);
        if (WR_EN === 1'b1) begin
            checkOutput("wr_addr_nonzero", (WR_ADDR != 5'd0), 1'b1);
        end
        @(negedge CLK);
    endtask

    int exp_counts[5] = '{2, 2, 2, 1, 0};

    initial begin
        RST_N = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(negedge CLK);
        checkOutput("rst_wr_en", WR_EN, 1'b0);
        checkOutput("rst_count", COUNT, 3'd0);
        checkOutput("rst_l_ready", L_READY, 1'b1);
        RST_N = 1'b1;
        stepCycle();
        stepCycle();

        // Pipeline writes: one-cycle latency, x0 dropped
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("a_wr_en", WR_EN, 1'b1);
        checkOutput("a_wr_addr", WR_ADDR, 5'd5);
        checkOutput("a_wr_data", WR_DATA, 32'hDEADBEEF);
        applyStimulus(1, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("a_x0_wr_en", WR_EN, 1'b0);
        checkOutput("a_x0_hold_data", WR_DATA, 32'hDEADBEEF);

        // Long-latency path with scoreboard
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
        #1 checkOutput("issue_busy1", BUSY1, 1'b1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        stepCycle();
        checkOutput("l_wr_data", WR_DATA, 32'h1234);
        checkOutput("l_busy_clear", BUSY1, 1'b0);
        stepCycle();

        // Contention: two queued entries wait behind three A writes
        applyStimulus(1, 3, 32'hA0, 1, 10, 32'hB0, 1, 10, 10, 11);
        stepCycle();
        applyStimulus(1, 4, 32'hA1, 1, 11, 32'hB1, 1, 11, 10, 11);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) applyStimulus(1, 5'(20 + i), 32'hC0 + i, 0, 0, 0, 0, 0, 10, 11);
            else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 10, 11);
            stepCycle();
            checkOutput("contention_count", COUNT, exp_counts[i]);
        end

        // Fill to full while A is busy, then drain while still offering L data
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 32'h100 + i, 1, 5'(12 + i), 32'h200 + i, 0, 0, 0, 0);
            stepCycle();
        end
        checkOutput("full_count", COUNT, 3'd4);
        checkOutput("full_l_ready", L_READY, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 1, 5'(24 + (i % 8)), 32'h300 + i, 0, 0, 0, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) stepCycle();

        // Scoreboard collision: re-issue x9 on the cycle its old result pops
        applyStimulus(1, 2, 32'h5, 1, 9, 32'h99, 1, 9, 9, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        stepCycle();
        checkOutput("collision_busy", BUSY1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
        stepCycle();
        checkOutput("issue_x0_busy", BUSY1, 1'b0);

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (i == 400) begin
                #2 RST_N = 1'b0;
                #1;
                modelReset();
                checkOutput("async_rst_wr_en", WR_EN, 1'b0);
                checkOutput("async_rst_count", COUNT, 3'd0);
                checkOutput("async_rst_l_ready", L_READY, 1'b1);
                checkOutput("async_rst_busy", {BUSY1, BUSY2}, 2'b00);
                @(negedge CLK);
                RST_N = 1'b1;
            end
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
